// File: rtl/bin8_to_7seg_display_if.sv
// Display bus: binary value in, BCD digits and 7-segment patterns out.
interface bin8_to_7seg_display_if;
    logic [7:0]  i_dec;
    logic [11:0] o_bcd;
    logic [6:0]  o_seg0;
    logic [6:0]  o_seg1;
    logic [6:0]  o_seg2;
    logic        o_valid;

    // Producer of the value to display (parameter-control block / testbench)
    modport master (
        output i_dec,
        input  o_bcd, o_seg0, o_seg1, o_seg2, o_valid
    );

    // The converter itself
    modport slave (
        input  i_dec,
        output o_bcd, o_seg0, o_seg1, o_seg2, o_valid
    );
endinterface

// File: rtl/bin8_to_7seg_display.sv
// 8-bit binary to three BCD digits with registered 7-segment patterns.
// Conversion is combinational double-dabble; all outputs are registered (latency 1).
module bin8_to_7seg_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b0
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    bin8_to_7seg_display_if.slave        disp
);

    localparam int unsigned BIN_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned SCR_W = BCD_W + BIN_W;

    localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // Shift-and-add-3 over all 8 input bits; exact for 0..255
    function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [BIN_W-1:0] bin);
        logic [SCR_W-1:0] scratch;
        scratch = {BCD_W'(0), bin};
        for (int i = 0; i < int'(BIN_W); i++) begin
            if (scratch[11:8]  >= 4'd5) scratch[11:8]  = scratch[11:8]  + 4'd3;
            if (scratch[15:12] >= 4'd5) scratch[15:12] = scratch[15:12] + 4'd3;
            if (scratch[19:16] >= 4'd5) scratch[19:16] = scratch[19:16] + 4'd3;
            scratch = scratch << 1;
        end
        return scratch[SCR_W-1:BIN_W];
    endfunction

    // Full hex table, active-low {g..a}; inverted when segments are active-high
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] code;
        unique case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return SEG_ACTIVE_LOW ? code : ~code;
    endfunction

    logic [BCD_W-1:0] bcd_c;
    logic [BCD_W-1:0] bcd_d,  bcd_q;
    logic [SEG_W-1:0] seg0_d, seg0_q;
    logic [SEG_W-1:0] seg1_d, seg1_q;
    logic [SEG_W-1:0] seg2_d, seg2_q;
    logic             valid_q;

    // Next-state: convert current input, decode digits, apply leading-zero blanking
    always_comb begin
        bcd_c  = bin_to_bcd(disp.i_dec);
        bcd_d  = bcd_c;
        seg0_d = hex_to_seg(bcd_c[3:0]);
        seg1_d = hex_to_seg(bcd_c[7:4]);
        seg2_d = hex_to_seg(bcd_c[11:8]);
        if (BLANK_LEADING) begin
            if (bcd_c[11:8] == 4'd0) begin
                seg2_d = SEG_OFF;
                if (bcd_c[7:4] == 4'd0) seg1_d = SEG_OFF;
            end
        end
    end

    // Output registers; reset forces all segments off and drops valid
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            bcd_q   <= '0;
            seg0_q  <= SEG_OFF;
            seg1_q  <= SEG_OFF;
            seg2_q  <= SEG_OFF;
            valid_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            seg0_q  <= seg0_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
            valid_q <= 1'b1;
        end
    end

    assign disp.o_bcd   = bcd_q;
    assign disp.o_seg0  = seg0_q;
    assign disp.o_seg1  = seg1_q;
    assign disp.o_seg2  = seg2_q;
    assign disp.o_valid = valid_q;

endmodule

// File: tb/tb_bin8_to_7seg_display.sv
// Bench for bin8_to_7seg_display: three parameterisations driven in lockstep,
// checked against a decimal-arithmetic reference model.
module tb_bin8_to_7seg_display;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 i_clock = ~i_clock;

    bin8_to_7seg_display_if if_a ();   // active-low, no blanking
    bin8_to_7seg_display_if if_b ();   // active-low, blanking
    bin8_to_7seg_display_if if_c ();   // active-high, blanking

    bin8_to_7seg_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_a (
        .i_clock(i_clock), .i_reset(i_reset), .disp(if_a));
    bin8_to_7seg_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_b (
        .i_clock(i_clock), .i_reset(i_reset), .disp(if_b));
    bin8_to_7seg_display #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_c (
        .i_clock(i_clock), .i_reset(i_reset), .disp(if_c));

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] ref_seg(input int digit, input bit al, input bit off);
        logic [6:0] code;
        code = off ? 7'h7F : seg_tbl[digit];
        return al ? code : ~code;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one DUT against the model for value v
    task automatic check_dut(input string name, input bit al, input bit bl, input int v,
                             input logic [11:0] bcd, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2, input logic vld);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        check({name, ".bcd"},   bcd, 12'(h * 256 + t * 16 + o));
        check({name, ".seg0"},  12'(s0), 12'(ref_seg(o, al, 1'b0)));
        check({name, ".seg1"},  12'(s1), 12'(ref_seg(t, al, bl && h == 0 && t == 0)));
        check({name, ".seg2"},  12'(s2), 12'(ref_seg(h, al, bl && h == 0)));
        check({name, ".valid"}, 12'(vld), 12'(1));
    endtask

    task automatic check_all(input int v);
        check_dut("a", 1'b1, 1'b0, v, if_a.o_bcd, if_a.o_seg0, if_a.o_seg1, if_a.o_seg2, if_a.o_valid);
        check_dut("b", 1'b1, 1'b1, v, if_b.o_bcd, if_b.o_seg0, if_b.o_seg1, if_b.o_seg2, if_b.o_valid);
        check_dut("c", 1'b0, 1'b1, v, if_c.o_bcd, if_c.o_seg0, if_c.o_seg1, if_c.o_seg2, if_c.o_valid);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".a.bcd"},   if_a.o_bcd, 12'h000);
        check({tag, ".a.seg0"},  12'(if_a.o_seg0), 12'h07F);
        check({tag, ".a.seg1"},  12'(if_a.o_seg1), 12'h07F);
        check({tag, ".a.seg2"},  12'(if_a.o_seg2), 12'h07F);
        check({tag, ".a.valid"}, 12'(if_a.o_valid), 12'h000);
        check({tag, ".b.seg2"},  12'(if_b.o_seg2), 12'h07F);
        check({tag, ".b.valid"}, 12'(if_b.o_valid), 12'h000);
        check({tag, ".c.bcd"},   if_c.o_bcd, 12'h000);
        check({tag, ".c.seg0"},  12'(if_c.o_seg0), 12'h000);
        check({tag, ".c.seg2"},  12'(if_c.o_seg2), 12'h000);
    endtask

    task automatic drive(input int v);
        if_a.i_dec = 8'(v);
        if_b.i_dec = 8'(v);
        if_c.i_dec = 8'(v);
    endtask

    // Drive at the falling edge, check just after the following rising edge
    task automatic step(input int v);
        @(negedge i_clock);
        drive(v);
        @(posedge i_clock);
        #1;
        check_all(v);
    endtask

    initial begin
        int v;
        drive(0);

        // Reset held with the clock running
        repeat (3) @(posedge i_clock);
        #1;
        check_reset_state("rst");

        // Release with 0: all zeros displayed (blanked variants keep only ones)
        @(negedge i_clock);
        i_reset = 1'b1;
        drive(0);
        @(posedge i_clock);
        #1;
        check_all(0);
        check("a.zero.seg2", 12'(if_a.o_seg2), 12'h040);

        // Directed values
        step(70);
        check("a.70.seg1", 12'(if_a.o_seg1), 12'h078);
        step(99);
        check("a.99.seg0", 12'(if_a.o_seg0), 12'h010);
        step(100);
        check("a.100.seg2", 12'(if_a.o_seg2), 12'h079);
        step(255);
        check("a.255.bcd", if_a.o_bcd, 12'h255);
        step(7);
        check("b.7.seg1", 12'(if_b.o_seg1), 12'h07F);
        check("b.7.seg0", 12'(if_b.o_seg0), 12'h078);
        step(105);
        check("b.105.seg1", 12'(if_b.o_seg1), 12'h040);
        step(10);
        step(9);

        // Input change between edges has no effect on outputs
        @(negedge i_clock);
        drive(200);
        #2;
        check_all(9);
        drive(9);
        @(posedge i_clock);
        #1;
        check_all(9);

        // Asynchronous reset between edges while showing 42
        step(42);
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge i_clock);
        #1;
        check_reset_state("rst_hold");
        @(negedge i_clock);
        i_reset = 1'b1;
        drive(42);
        @(posedge i_clock);
        #1;
        check_all(42);
        check("a.42.seg1", 12'(if_a.o_seg1), 12'h019);
        check("a.42.seg0", 12'(if_a.o_seg0), 12'h024);

        // Exhaustive sweep
        for (int i = 0; i < 256; i++) step(i);

        // Random values
        for (int i = 0; i < 300; i++) begin
            v = int'($urandom_range(255, 0));
            step(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
